// File: rtl/encoder_16to4_pipe.sv
// 16-to-4 priority encoder, two-stage valid/ready pipeline.
// Stage 1 encodes each byte independently; stage 2 merges the two byte results.

module enc8_byte #(
    parameter int PRIORITY_HIGH = 1
) (
    input  logic [7:0] i_d,
    output logic [2:0] o_idx,
    output logic       o_any,
    output logic       o_multi
);
    always_comb begin
        o_idx = 3'd0;
        if (PRIORITY_HIGH != 0) begin
            for (int i = 0; i < 8; i++)
                if (i_d[i]) o_idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (i_d[i]) o_idx = 3'(i);
        end
    end

    assign o_any   = |i_d;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_multi = |(i_d & (i_d - 8'd1));
endmodule

module encoder_16to4_pipe #(
    parameter int PRIORITY_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  y,
    output logic        any,
    output logic        multi
);
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic [2:0] idx;
        logic       any;
        logic       multi;
    } byte_res_t;

    byte_res_t [NUM_LANES-1:0] w_byte;
    byte_res_t [NUM_LANES-1:0] r_s1;
    logic                      r_s1_valid;
    logic                      r_out_valid;
    logic [3:0]                r_y;
    logic                      r_any;
    logic                      r_multi;
    logic                      w_s2_load;
    logic                      w_s1_load;
    logic [3:0]                w_y;
    logic                      w_any;
    logic                      w_multi;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            enc8_byte #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_enc (
                .i_d     (d[g*8 +: 8]),
                .o_idx   (w_byte[g].idx),
                .o_any   (w_byte[g].any),
                .o_multi (w_byte[g].multi)
            );
        end
    endgenerate

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Merge the byte results; an all-zero word must encode to 0 for either priority.
    always_comb begin
        w_any   = r_s1[1].any || r_s1[0].any;
        w_multi = r_s1[1].multi || r_s1[0].multi || (r_s1[1].any && r_s1[0].any);
        w_y     = 4'd0;
        if (PRIORITY_HIGH != 0) begin
            if (r_s1[1].any) w_y = {1'b1, r_s1[1].idx};
            else             w_y = {1'b0, r_s1[0].idx};
        end else begin
            if (r_s1[0].any) w_y = {1'b0, r_s1[0].idx};
            else             w_y = {1'b1, r_s1[1].idx};
        end
        if (!w_any) w_y = 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1 <= w_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= 4'd0;
            r_any       <= 1'b0;
            r_multi     <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_y;
                r_any   <= w_any;
                r_multi <= w_multi;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign any       = r_any;
    assign multi     = r_multi;
endmodule

// File: tb/tb_encoder_16to4_pipe.sv
// Directed bench: high-priority and low-priority instances share all inputs.

module tb_encoder_16to4_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] d;
    logic        out_ready;
    logic        in_ready_h, in_ready_l;
    logic        out_valid_h, out_valid_l;
    logic [3:0]  y_h, y_l;
    logic        any_h, any_l;
    logic        multi_h, multi_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder_16to4_pipe #(.PRIORITY_HIGH(1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h),
        .d(d), .out_valid(out_valid_h), .out_ready(out_ready),
        .y(y_h), .any(any_h), .multi(multi_h)
    );

    encoder_16to4_pipe #(.PRIORITY_HIGH(0)) u_dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .d(d), .out_valid(out_valid_l), .out_ready(out_ready),
        .y(y_l), .any(any_l), .multi(multi_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, then advance to just past the next rising edge.
    task automatic step(input logic v, input logic [15:0] dat);
        in_valid = v;
        d        = dat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d         = 16'h0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid_h), 32'd0);
        chk("rst_y",         32'(y_h),         32'd0);
        chk("rst_any_multi", {any_h, multi_h}, 32'd0);
        chk("rst_in_ready",  32'(in_ready_h),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel_in_ready",  32'(in_ready_h),  32'd1);

        // One-hot sweep, back to back
        for (int c = 0; c < 18; c++) begin
            step(c < 16, (c < 16) ? (16'h1 << c) : 16'h0);
            if (c >= 1 && c <= 16) begin
                chk($sformatf("sweep_vld_%0d", c - 1), 32'(out_valid_h), 32'd1);
                chk($sformatf("sweep_y_%0d", c - 1),   32'(y_h), 32'(c - 1));
                chk($sformatf("sweep_yl_%0d", c - 1),  32'(y_l), 32'(c - 1));
                chk($sformatf("sweep_am_%0d", c - 1),  {any_h, multi_h}, 32'b10);
            end
        end
        chk("sweep_drained", 32'(out_valid_h), 32'd0);

        // Priority cases
        step(1'b1, 16'h0A00);
        step(1'b0, 16'h0);
        chk("p0a00_vld",  32'(out_valid_h), 32'd1);
        chk("p0a00_yh",   32'(y_h), 32'd11);
        chk("p0a00_yl",   32'(y_l), 32'd9);
        chk("p0a00_mh",   {any_h, multi_h}, 32'b11);
        chk("p0a00_ml",   {any_l, multi_l}, 32'b11);
        step(1'b1, 16'h8001);
        step(1'b0, 16'h0);
        chk("p8001_yh",   32'(y_h), 32'd15);
        chk("p8001_yl",   32'(y_l), 32'd0);
        chk("p8001_ml",   {multi_h, multi_l}, 32'b11);

        // Zero word must still produce a result
        step(1'b1, 16'h0000);
        step(1'b0, 16'h0);
        chk("zero_vld",   {out_valid_h, out_valid_l}, 32'b11);
        chk("zero_yh",    32'(y_h), 32'd0);
        chk("zero_yl",    32'(y_l), 32'd0);
        chk("zero_am",    {any_h, multi_h, any_l, multi_l}, 32'd0);
        step(1'b0, 16'h0);
        chk("zero_drain", 32'(out_valid_h), 32'd0);

        // Backpressure: two words fill the pipe, third is refused
        out_ready = 1'b0;
        step(1'b1, 16'h0004);
        in_valid = 1'b1; d = 16'h0040; #1;
        chk("bp_rdy_2nd", 32'(in_ready_h), 32'd1);
        step(1'b1, 16'h0040);
        chk("bp_y_2",     32'(y_h), 32'd2);
        d = 16'h4000; #1;
        chk("bp_full",    {in_ready_h, in_ready_l}, 32'd0);
        step(1'b1, 16'h4000);
        chk("bp_hold_y",  32'(y_h), 32'd2);
        chk("bp_hold_v",  32'(out_valid_h), 32'd1);
        step(1'b1, 16'h4000);
        chk("bp_hold_y2", 32'(y_h), 32'd2);
        chk("bp_hold_r",  32'(in_ready_h), 32'd0);
        out_ready = 1'b1; #1;
        chk("bp_rdy_comb", 32'(in_ready_h), 32'd1);
        step(1'b1, 16'h4000);
        chk("bp_y_6",     32'(y_h), 32'd6);
        step(1'b0, 16'h0);
        chk("bp_y_14",    32'(y_h), 32'd14);
        chk("bp_v_14",    32'(out_valid_h), 32'd1);
        step(1'b0, 16'h0);
        chk("bp_empty",   32'(out_valid_h), 32'd0);

        // Reset with two words in flight
        out_ready = 1'b0;
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0002);
        in_valid = 1'b0;
        chk("rm_full_v",  32'(out_valid_h), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_vld",     {out_valid_h, out_valid_l}, 32'd0);
        chk("rm_y",       32'(y_h), 32'd0);
        chk("rm_rdy",     32'(in_ready_h), 32'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step(1'b0, 16'h0);
        chk("rm_no_stale", 32'(out_valid_h), 32'd0);
        chk("rm_rdy_after", 32'(in_ready_h), 32'd1);
        step(1'b0, 16'h0);
        chk("rm_no_stale2", 32'(out_valid_h), 32'd0);
        step(1'b1, 16'h0100);
        step(1'b0, 16'h0);
        chk("rm_next_v",  32'(out_valid_h), 32'd1);
        chk("rm_next_yh", 32'(y_h), 32'd8);
        chk("rm_next_yl", 32'(y_l), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
